// File: rtl/keccak_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_ctrl
//
// Sequencing controller for the Keccak-f[1600] accelerator. It accepts
// start/abort/clear commands from the peripheral register file and steps the
// permutation core through LOAD -> ROUND x ROUNDS -> STORE. It also arbitrates
// the shared state buffer between the external bus slave port and the core.
//
// Optional feature macro: KECCAK_CTRL_INTR_EN
//   defined   : intr_o exists and pulses for one cycle when done_o rises
//   undefined : no intr_o port; software polls done_o
//
// Parameters
//   ROUNDS  rounds per permutation (1..24); indices run 24-ROUNDS .. 23
//   IDX_W   width of the round-constant index
//
// Ports
//   clk_i             system clock, rising edge
//   rst_i             synchronous active-high reset
//   start_i           start pulse (taken only in IDLE)
//   abort_i           abort pulse (ignored in IDLE)
//   clear_i           clears the done_o / aborted_o sticky flags
//   busy_o            high in LOAD, ROUND and STORE
//   done_o            sticky: permutation completed
//   aborted_o         sticky: last run was aborted
//   core_load_o       core latches the buffer into its state register
//   core_round_en_o   core executes one round this cycle
//   core_round_idx_o  round-constant index (0 outside ROUND)
//   core_store_o      core writes its state back to the buffer
//   intr_o            completion interrupt (KECCAK_CTRL_INTR_EN only)
//   bus_req_i         slave port requests buffer access
//   bus_gnt_o         combinational grant to the slave port
// -----------------------------------------------------------------------------
module keccak_ctrl #(
   parameter int ROUNDS = 24,
   parameter int IDX_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             clear_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic             core_load_o,
   output logic             core_round_en_o,
   output logic [IDX_W-1:0] core_round_idx_o,
   output logic             core_store_o,
`ifdef KECCAK_CTRL_INTR_EN
   output logic             intr_o,
`endif
   input  logic             bus_req_i,
   output logic             bus_gnt_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_STORE = 2'd3;

   // Reduced-round variants run the tail of the round-constant table.
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(24 - ROUNDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(23);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic             r_done;
   logic             r_aborted;
   logic             w_idle;
   logic             w_start_acc;
   logic             w_abort_acc;
   logic             w_finish;

   assign w_idle      = (r_state == S_IDLE);
   // start wins over a coincident abort because abort is only honoured
   // outside IDLE.
   assign w_start_acc = w_idle & start_i;
   assign w_abort_acc = ~w_idle & abort_i;
   // An abort during STORE suppresses completion.
   assign w_finish    = (r_state == S_STORE) & ~abort_i;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_ROUND;
         S_ROUND: if (r_cnt == LAST_IDX) w_state_nxt = S_STORE;
         S_STORE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort_acc) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Round counter: preset during LOAD so it is valid on the first ROUND cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (r_state == S_LOAD) begin
         r_cnt <= FIRST_IDX;
      end else if ((r_state == S_ROUND) && !w_abort_acc) begin
         r_cnt <= r_cnt + IDX_W'(1);
      end
   end

   // Sticky flags: a set in the same cycle as clear_i takes priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         if (w_finish) begin
            r_done <= 1'b1;
         end else if (w_start_acc || clear_i) begin
            r_done <= 1'b0;
         end
         if (w_abort_acc) begin
            r_aborted <= 1'b1;
         end else if (w_start_acc || clear_i) begin
            r_aborted <= 1'b0;
         end
      end
   end

`ifdef KECCAK_CTRL_INTR_EN
   logic r_intr;

   // Registered alongside r_done so the pulse coincides with done_o rising.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_intr <= 1'b0;
      end else begin
         r_intr <= w_finish;
      end
   end

   assign intr_o = r_intr;
`endif

   assign busy_o           = ~w_idle;
   assign done_o           = r_done;
   assign aborted_o        = r_aborted;
   assign core_load_o      = (r_state == S_LOAD);
   assign core_round_en_o  = (r_state == S_ROUND);
   assign core_round_idx_o = core_round_en_o ? r_cnt : '0;
   assign core_store_o     = (r_state == S_STORE);
   // A request coinciding with start_i loses; the core owns the buffer next.
   assign bus_gnt_o        = bus_req_i & w_idle & ~start_i;

endmodule
